// File: rtl/agnmt_pkg.sv
// Shared types and constants for the agnmt pulse-train generator.
package agnmt_pkg;

    // Width of the period counter and of the N / MT controls.
    localparam int W = 11;

    typedef logic [W-1:0] cnt_t;

    // True when the counter must wrap on the next ce tick.
    // Unsigned compare; MT of 0 or 1 collapses the period to a single tick.
    function automatic logic is_term(input cnt_t q, input cnt_t mt);
        return (mt <= cnt_t'(1)) || (q >= mt - cnt_t'(1));
    endfunction

endpackage

// File: rtl/agnmt_if.sv
// Control/status bundle of the agnmt pulse-train generator.
// master drives ce/N/MT and observes the pulse outputs; slave is the generator.
interface agnmt_if;
    import agnmt_pkg::*;

    logic ce;
    cnt_t N;
    cnt_t MT;
    cnt_t q;
    logic PW;
    logic start_PW;
    logic end_PW;

    modport master (output ce, N, MT, input q, PW, start_PW, end_PW);
    modport slave  (input ce, N, MT, output q, PW, start_PW, end_PW);
endinterface

// File: rtl/agnmt_counter.sv
// Modulo-MT period counter advanced by a clock-enable tick.
// term flags the last tick of the period (or a degenerate MT of 0/1).
module agnmt_counter
    import agnmt_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  cnt_t mt,
    output cnt_t q,
    output logic term
);

    cnt_t q_reg;
    cnt_t q_next;

    assign term = is_term(q_reg, mt);
    assign q    = q_reg;

    // Next count: wrap to zero at the terminal value, hold without a tick.
    always_comb begin
        q_next = q_reg;
        if (ce) begin
            q_next = term ? '0 : q_reg + cnt_t'(1);
        end
    end

    // Count register; reset wins over ce.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

endmodule

// File: rtl/agnmt.sv
// agnmt: programmable pulse-train generator.
// PW is high for the first N ce ticks of every MT-tick period, with
// one-clock strobes on the tick that leaves q=0 and on the last pulse tick.
// Build option AGNMT_SHADOW_EN: N and MT are sampled at reset and at each
// period boundary so that mid-period changes apply from the next period.
module agnmt
    import agnmt_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    agnmt_if.slave  bus
);

    cnt_t n_eff;
    cnt_t mt_eff;
    cnt_t q_cur;
    logic term;

    agnmt_counter u_counter (
        .clk  (clk),
        .rst  (rst),
        .ce   (bus.ce),
        .mt   (mt_eff),
        .q    (q_cur),
        .term (term)
    );

`ifdef AGNMT_SHADOW_EN
    cnt_t n_sh_reg;
    cnt_t mt_sh_reg;

    // Capture N/MT at reset and at each period boundary only.
    always_ff @(posedge clk) begin
        if (rst || (bus.ce && term)) begin
            n_sh_reg  <= bus.N;
            mt_sh_reg <= bus.MT;
        end
    end

    assign n_eff  = n_sh_reg;
    assign mt_eff = mt_sh_reg;
`else
    assign n_eff  = bus.N;
    assign mt_eff = bus.MT;
`endif

    logic n_nz;
    assign n_nz = (n_eff != '0);

    // Pulse level and edge strobes, all forced low while reset is asserted.
    always_comb begin
        bus.PW       = ~rst & (q_cur < n_eff);
        bus.start_PW = ~rst & bus.ce & n_nz & (q_cur == '0);
        bus.end_PW   = ~rst & bus.ce & n_nz & (n_eff < mt_eff)
                     & (q_cur == n_eff - cnt_t'(1));
    end

    assign bus.q = q_cur;

endmodule

// File: tb/tb_agnmt.sv
// Scoreboard bench for agnmt: the driver pushes expected outputs from a
// period/pulse reference model; a monitor on the falling edge compares.
module tb_agnmt;

    logic clk = 1'b0;
    logic rst = 1'b1;

    agnmt_if bus ();

    agnmt dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [10:0] q;
        logic        pw;
        logic        st;
        logic        en;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model state: position within the period plus latched controls.
    int m_q   = 0;
    int sh_n  = 0;
    int sh_mt = 0;
    int cur_n = 0;
    int cur_m = 0;

    // One clock of stimulus: drive inputs, predict this cycle's outputs,
    // then advance the model across the coming edge.
    task automatic step(input bit r, input bit c, input int n, input int m);
        int   ne;
        int   me;
        int   period;
        exp_t e;
        @(posedge clk);
        #1;
        rst    = r;
        bus.ce = c;
        bus.N  = n[10:0];
        bus.MT = m[10:0];
        cur_n  = n;
        cur_m  = m;
`ifdef AGNMT_SHADOW_EN
        ne = sh_n;
        me = sh_mt;
`else
        ne = n;
        me = m;
`endif
        e.q  = m_q[10:0];
        e.pw = !r && (m_q < ne);
        e.st = !r && c && (m_q == 0) && (ne != 0);
        e.en = !r && c && (ne != 0) && (ne < me) && (m_q == ne - 1);
        sb.push_back(e);
        period = (me > 1) ? me : 1;
        if (r) begin
            m_q   = 0;
            sh_n  = n;
            sh_mt = m;
        end else if (c) begin
            if (m_q + 1 >= period) begin
                m_q   = 0;
                sh_n  = n;
                sh_mt = m;
            end else begin
                m_q = m_q + 1;
            end
        end
    endtask

    // Monitor: every cycle the DUT presents outputs; compare mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            exp_t a;
            e = sb.pop_front();
            a = '{q: bus.q, pw: bus.PW, st: bus.start_PW, en: bus.end_PW};
            n_cmp = n_cmp + 1;
            if (a !== e) begin
                n_fail = n_fail + 1;
                $display("FAIL outputs t=%0t: got q=%0d PW=%b st=%b end=%b, need q=%0d PW=%b st=%b end=%b",
                         $time, a.q, a.pw, a.st, a.en, e.q, e.pw, e.st, e.en);
            end else begin
                $display("txn t=%0t q=%0d PW=%b st=%b end=%b ok", $time, a.q, a.pw, a.st, a.en);
            end
        end
    end

    initial begin
        bus.ce = 1'b0;
        bus.N  = '0;
        bus.MT = '0;
        @(posedge clk);     // first reset edge establishes q=0

        // Reset held with ce toggling.
        for (int i = 0; i < 3; i++) step(1'b1, i[0], 15, 20);

        // MT=20, N=15, ce every second clock for 10 us.
        for (int i = 0; i < 500; i++) step(1'b0, i[0], 15, 20);

        // N=0: no pulse; N>=MT: pulse never ends.
        for (int i = 0; i < 60; i++) step(1'b0, 1'b1, 0, 10);
        for (int i = 0; i < 60; i++) step(1'b0, 1'b1, 12, 10);

        // Degenerate periods with a one-tick pulse.
        for (int i = 0; i < 20; i++) step(1'b0, i[0], 1, 0);
        for (int i = 0; i < 20; i++) step(1'b0, i[0], 1, 1);

        // Shrink MT while q sits at 18.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 15, 20);
        for (int i = 0; i < 100 && m_q != 18; i++) step(1'b0, 1'b1, 15, 20);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 15, 10);

        // Reset pulse in mid-period at q=7.
        for (int i = 0; i < 100 && m_q != 7; i++) step(1'b0, 1'b1, 15, 20);
        step(1'b1, 1'b1, 15, 20);
        for (int i = 0; i < 30; i++) step(1'b0, i[0], 15, 20);

        // Randomized controls, ce and occasional resets.
        for (int i = 0; i < 2500; i++) begin
            int n;
            int m;
            n = cur_n;
            m = cur_m;
            if ($urandom_range(0, 39) == 0) n = $urandom_range(0, 25);
            if ($urandom_range(0, 39) == 0) m = $urandom_range(0, 25);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, n, m);
        end

        @(negedge clk);
        @(negedge clk);
        n_cmp = n_cmp + 1;
        if (sb.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain: %0d entries left, need 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard time bound for the whole run.
    initial begin
        #5ms;
        $display("FAIL timeout: run still active at %0t, need finish earlier", $time);
        $fatal(1, "timeout");
    end

endmodule
